mac_dot_sequencer: RTL and testbench
====================================

// Module: mac_dot_sequencer
// PURPOSE
//  Sequences a single shared 16x16 multiplier plus accumulator to compute unsigned dot products
//  sum(x[i]*y[i]) over a streamed vector of operand pairs.
//  Sits between an operand source (valid/ready, last-marked) and a result consumer (valid/ready).
//  Replaces a fixed three-product MAC with a variable-length, back-pressured, pipelined engine.
// PARAMETERS
//  DATA_W   16  operand width, unsigned
//  ACC_W    32  accumulator/result width, must be >= 2*DATA_W
//  MAX_LEN  8   maximum pairs per vector; count width CNT_W = $clog2(MAX_LEN+1)
// PORTS
//  i_Clk        in   1       clock, all logic on rising edge
//  i_Rst_L      in   1       asynchronous, active-low reset
//  i_x          in   DATA_W  operand x[i]
//  i_y          in   DATA_W  operand y[i]
//  i_Valid      in   1       operand pair valid
//  i_Last       in   1       pair is final element of vector (qualified by i_Valid)
//  o_Ready      out  1       sequencer accepts pair this cycle
//  i_Abort      in   1       synchronous discard of vector in progress
//  o_Sum        out  ACC_W   dot-product result
//  o_Count      out  CNT_W   pairs accumulated into o_Sum
//  o_Trunc      out  1       vector cut at MAX_LEN without i_Last
//  o_Sat        out  1       accumulator saturated (only with MAC_SEQ_SAT_EN, else 0)
//  o_Out_Valid  out  1       result valid; held until accepted
//  i_Out_Ready  in   1       consumer accepts result
// BEHAVIOUR
//  - Reset: state IDLE, o_Sum=0, o_Count=0, o_Trunc=0, o_Sat=0, o_Out_Valid=0, pipeline valid=0.
//  - Accept = i_Valid & o_Ready. o_Ready = (state==IDLE|RUN) & !i_Abort (combinational; 1 after reset).
//  - Stage 1 (accept edge k): r_Prod <= i_x*i_y (2*DATA_W, zero-ext to ACC_W); tag first/last.
//  - Stage 2 (edge k+1): acc <= first ? r_Prod : acc + r_Prod; count increments.
//  - Latency: o_Out_Valid rises 2 edges after the edge accepting the last pair; 1 pair/cycle throughput.
//  - FSM: IDLE -accept-> RUN (or DRAIN if pair is last); RUN -accept last-> DRAIN;
//    DRAIN -last product accumulated-> DONE; DONE -o_Out_Valid & i_Out_Ready-> IDLE.
//  - DRAIN/DONE: o_Ready=0; o_Sum/o_Count/o_Trunc/o_Sat stable while o_Out_Valid=1 and not accepted.
//  - Next vector may be accepted the cycle after the result handshake (IDLE); no overlap.
//  - MAX_LEN: pair accepted with count == MAX_LEN-1 and i_Last=0 is treated as last; o_Trunc=1.
//  - Empty vector impossible: i_Last only meaningful with an accepted pair.
//  - Overflow (default): accumulator wraps modulo 2^ACC_W, no flag.
//  - i_Abort: any state -> IDLE next edge; pipeline valid cleared; o_Out_Valid=0; no result output.
//    Abort with i_Valid same cycle: pair not accepted. Abort in DONE discards the held result.
//  - i_Out_Ready ignored when o_Out_Valid=0. i_x/i_y/i_Last ignored when not accepted.
//  - Async reset mid-vector: immediate return to reset values; partial vector lost.
// CONFIGURATION
//  - MAC_SEQ_SAT_EN defined: stage-2 add saturates to {ACC_W{1'b1}}; o_Sat set on first
//    saturating add, sticky until the next vector starts (cleared on first-pair accumulate).
//  - MAC_SEQ_SAT_EN undefined: wrap-around add; o_Sat tied 0; no saturation logic synthesized.
// TESTING
//  1. Pairs (B1C5,CE5F),(5489,A76C),(1DEA... ) : (B1C5,CE5F),(5489,A76C),(1D86,1DEA,last) on
//     consecutive cycles -> o_Sum=32'hCA0AB163, o_Count=3, o_Out_Valid 2 edges after 3rd accept.
//  2. (FFFF,FFFF),(FFFF,FFFF,last): default -> o_Sum=32'hFFFC0002, o_Sat=0;
//     MAC_SEQ_SAT_EN -> o_Sum=32'hFFFFFFFF, o_Sat=1.
//  3. MAX_LEN=8, nine (0001,0001) pairs, i_Last=0 -> o_Sum=8, o_Count=8, o_Trunc=1;
//     9th pair stalls (o_Ready=0) until result accepted, then starts new vector.
//  4. Result with i_Out_Ready=0 for 5 cycles -> outputs stable, o_Ready=0; IDLE the edge after accept.
//  5. i_Abort after 2 of 3 pairs, then (0002,0003,last) -> o_Sum=6, o_Count=1; abort+valid not accepted.
//  6. i_Rst_L low mid-vector (async, between edges) -> all outputs reset immediately; o_Ready=1 after.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// Streams operand pairs through one shared multiplier and an accumulator to form unsigned dot products.
// Optional: define MAC_SEQ_SAT_EN for a saturating accumulate with a sticky o_Sat flag.
module mac_dot_sequencer #(
   parameter int  DATA_W  = 16,
   parameter int  ACC_W   = 32,
   parameter int  MAX_LEN = 8,
   localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   input  logic [DATA_W-1:0] i_x,
   input  logic [DATA_W-1:0] i_y,
   input  logic              i_Valid,
   input  logic              i_Last,
   output logic              o_Ready,
   input  logic              i_Abort,
   output logic [ACC_W-1:0]  o_Sum,
   output logic [CNT_W-1:0]  o_Count,
   output logic              o_Trunc,
   output logic              o_Sat,
   output logic              o_Out_Valid,
   input  logic              i_Out_Ready
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic                first;
      logic                trunc;
      logic [2*DATA_W-1:0] prod;
   } s1_t;

   // bit 0: product registered, bit 1: product accumulated
   localparam int STAGES = 1;

   state_t           state, state_nxt;
   logic [STAGES:0]  vld_pipe, lst_pipe;
   s1_t              s1;
   logic [CNT_W-1:0] issue_cnt, cnt_base, acc_cnt;
   logic [ACC_W-1:0] acc, acc_nxt, prod_ext;
   logic             accept, is_last, trunc_hit, trunc_r;

   assign o_Ready     = (state == IDLE || state == RUN) && !i_Abort;
   assign accept      = i_Valid && o_Ready;
   assign o_Out_Valid = (state == DONE);
   assign o_Sum       = acc;
   assign o_Count     = acc_cnt;
   assign o_Trunc     = trunc_r;

   // Issue count runs ahead of the accumulated count, so the length cap is judged at accept time.
   assign cnt_base  = (state == IDLE) ? '0 : issue_cnt;
   assign trunc_hit = (cnt_base == CNT_W'(MAX_LEN - 1)) && !i_Last;
   assign is_last   = i_Last || trunc_hit;
   assign prod_ext  = ACC_W'(s1.prod);

   always_comb begin
      state_nxt = state;
      if (i_Abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nxt = is_last ? DRAIN : RUN;
            RUN:     if (accept && is_last) state_nxt = DRAIN;
            DRAIN:   if (vld_pipe[STAGES] && lst_pipe[STAGES]) state_nxt = DONE;
            DONE:    if (i_Out_Ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

`ifdef MAC_SEQ_SAT_EN
   logic             sat_r, sat_nxt;
   logic [ACC_W:0]   acc_sum;

   assign acc_sum = {1'b0, acc} + {1'b0, prod_ext};

   always_comb begin
      acc_nxt = acc_sum[ACC_W-1:0];
      sat_nxt = sat_r;
      if (s1.first) begin
         acc_nxt = prod_ext;
         sat_nxt = 1'b0;
      end else if (acc_sum[ACC_W]) begin
         acc_nxt = '1;
         sat_nxt = 1'b1;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L)                     sat_r <= 1'b0;
      else if (vld_pipe[0] && !i_Abort) sat_r <= sat_nxt;
   end

   assign o_Sat = sat_r;
`else
   always_comb begin
      acc_nxt = s1.first ? prod_ext : acc + prod_ext;
   end

   assign o_Sat = 1'b0;
`endif

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state     <= IDLE;
         vld_pipe  <= '0;
         lst_pipe  <= '0;
         s1        <= '0;
         issue_cnt <= '0;
         acc       <= '0;
         acc_cnt   <= '0;
         trunc_r   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (i_Abort) begin
            vld_pipe <= '0;
            lst_pipe <= '0;
         end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
            lst_pipe <= {lst_pipe[STAGES-1:0], accept && is_last};
         end
         if (accept) begin
            s1.first  <= (state == IDLE);
            s1.trunc  <= trunc_hit;
            s1.prod   <= {{DATA_W{1'b0}}, i_x} * {{DATA_W{1'b0}}, i_y};
            issue_cnt <= cnt_base + CNT_W'(1);
         end
         if (vld_pipe[0] && !i_Abort) begin
            acc     <= acc_nxt;
            acc_cnt <= s1.first ? CNT_W'(1) : acc_cnt + CNT_W'(1);
            trunc_r <= s1.trunc;
         end
      end
   end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: directed vectors plus random traffic against a vector-level model.
module tb_mac_dot_sequencer;
   localparam int DATA_W  = 16;
   localparam int ACC_W   = 32;
   localparam int MAX_LEN = 8;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);

   logic              i_Clk = 1'b0;
   logic              i_Rst_L = 1'b0;
   logic [DATA_W-1:0] i_x = '0, i_y = '0;
   logic              i_Valid = 1'b0, i_Last = 1'b0, i_Abort = 1'b0, i_Out_Ready = 1'b0;
   logic              o_Ready, o_Trunc, o_Sat, o_Out_Valid;
   logic [ACC_W-1:0]  o_Sum;
   logic [CNT_W-1:0]  o_Count;

   always #5 i_Clk = ~i_Clk;

   mac_dot_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
      .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_x(i_x), .i_y(i_y), .i_Valid(i_Valid),
      .i_Last(i_Last), .o_Ready(o_Ready), .i_Abort(i_Abort), .o_Sum(o_Sum),
      .o_Count(o_Count), .o_Trunc(o_Trunc), .o_Sat(o_Sat), .o_Out_Valid(o_Out_Valid),
      .i_Out_Ready(i_Out_Ready)
   );

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model state: pairs of the open vector, and the pending result once the vector closes.
   int unsigned      vx[$], vy[$];
   bit               busy = 0;
   int               age = 0;
   logic [ACC_W-1:0] e_sum;
   logic [CNT_W-1:0] e_cnt;
   logic             e_trunc, e_sat;
   logic [ACC_W-1:0] hs_sum;
   logic [CNT_W-1:0] hs_cnt;
   logic             hs_trunc, hs_sat;

   task automatic finish_vec(input bit trunc);
      longint unsigned s = 0;
      foreach (vx[i]) s += longint'(vx[i]) * longint'(vy[i]);
`ifdef MAC_SEQ_SAT_EN
      e_sat = (s > 64'hFFFF_FFFF);
      e_sum = e_sat ? '1 : ACC_W'(s);
`else
      e_sat = 1'b0;
      e_sum = ACC_W'(s);
`endif
      e_cnt   = CNT_W'(vx.size());
      e_trunc = trunc;
      busy    = 1;
      age     = 0;
      vx.delete();
      vy.delete();
   endtask

   // One clock: drive at the negedge, check, advance the model, step to the next negedge.
   task automatic cyc(input bit v, input logic [15:0] x, input logic [15:0] y,
                      input bit last, input bit abort, input bit ordy);
      bit exp_rdy, exp_ov;
      i_Valid = v; i_x = x; i_y = y; i_Last = last; i_Abort = abort; i_Out_Ready = ordy;
      #1;
      exp_rdy = !busy && !abort;
      exp_ov  = busy && age >= 2;
      chk("ready", o_Ready, exp_rdy);
      chk("out_valid", o_Out_Valid, exp_ov);
      if (exp_ov) begin
         chk("sum", o_Sum, e_sum);
         chk("count", o_Count, e_cnt);
         chk("trunc", o_Trunc, e_trunc);
         chk("sat", o_Sat, e_sat);
      end
      if (o_Out_Valid && ordy) begin
         hs_sum = o_Sum; hs_cnt = o_Count; hs_trunc = o_Trunc; hs_sat = o_Sat;
      end
      if (abort) begin
         busy = 0;
         vx.delete();
         vy.delete();
      end else if (v && exp_rdy) begin
         vx.push_back(x);
         vy.push_back(y);
         if (last)                      finish_vec(0);
         else if (vx.size() == MAX_LEN) finish_vec(1);
      end else if (busy) begin
         if (exp_ov && ordy) busy = 0;
         else if (age < 2)   age++;
      end
      @(posedge i_Clk);
      @(negedge i_Clk);
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) cyc(0, 16'(i), 16'(i), 0, 0, ordy);
   endtask

   initial begin
      #12;
      chk("rst_sum", o_Sum, 0);
      chk("rst_count", o_Count, 0);
      chk("rst_trunc", o_Trunc, 0);
      chk("rst_sat", o_Sat, 0);
      chk("rst_ovalid", o_Out_Valid, 0);
      chk("rst_ready", o_Ready, 1);
      @(negedge i_Clk);
      i_Rst_L = 1'b1;

      // three-pair vector, back to back
      cyc(1, 16'hB1C5, 16'hCE5F, 0, 0, 1);
      cyc(1, 16'h5489, 16'hA76C, 0, 0, 1);
      cyc(1, 16'h1D86, 16'h1DEA, 1, 0, 1);
      idle(3, 1);
      chk("t1_sum", hs_sum, 32'hCA0AB163);
      chk("t1_count", hs_cnt, 3);

      // overflow behaviour
      cyc(1, 16'hFFFF, 16'hFFFF, 0, 0, 1);
      cyc(1, 16'hFFFF, 16'hFFFF, 1, 0, 1);
      idle(3, 1);
`ifdef MAC_SEQ_SAT_EN
      chk("t2_sum", hs_sum, 32'hFFFFFFFF);
      chk("t2_sat", hs_sat, 1);
`else
      chk("t2_sum", hs_sum, 32'hFFFC0002);
      chk("t2_sat", hs_sat, 0);
`endif

      // length cap: ninth pair stalls until the truncated result is taken
      for (int i = 0; i < 12; i++) cyc(1, 16'h0001, 16'h0001, 0, 0, 0);
      cyc(1, 16'h0001, 16'h0001, 0, 0, 1);
      chk("t3_sum", hs_sum, 8);
      chk("t3_count", hs_cnt, 8);
      chk("t3_trunc", hs_trunc, 1);
      cyc(1, 16'h0001, 16'h0001, 1, 0, 1);
      idle(3, 1);
      chk("t3b_count", hs_cnt, 1);
      chk("t3b_trunc", hs_trunc, 0);

      // back-pressured result held stable
      cyc(1, 16'h0003, 16'h0004, 1, 0, 0);
      idle(7, 0);
      cyc(0, 16'h0, 16'h0, 0, 0, 1);
      chk("t4_sum", hs_sum, 12);
      cyc(1, 16'h0005, 16'h0005, 1, 0, 1);
      idle(3, 1);
      chk("t4b_sum", hs_sum, 25);

      // abort mid-vector; abort with valid is not accepted
      cyc(1, 16'h1234, 16'h4321, 0, 0, 1);
      cyc(1, 16'h1111, 16'h2222, 0, 0, 1);
      cyc(1, 16'h0005, 16'h0005, 1, 1, 1);
      cyc(1, 16'h0002, 16'h0003, 1, 0, 1);
      idle(3, 1);
      chk("t5_sum", hs_sum, 6);
      chk("t5_count", hs_cnt, 1);

      // abort discards a held result
      cyc(1, 16'h0009, 16'h0009, 1, 0, 0);
      idle(3, 0);
      cyc(0, 16'h0, 16'h0, 0, 1, 0);
      idle(3, 1);

      // async reset between edges
      cyc(1, 16'h0007, 16'h0007, 0, 0, 1);
      cyc(1, 16'h0007, 16'h0007, 0, 0, 1);
      #2 i_Rst_L = 1'b0;
      #1;
      chk("t6_sum", o_Sum, 0);
      chk("t6_count", o_Count, 0);
      chk("t6_ovalid", o_Out_Valid, 0);
      chk("t6_ready", o_Ready, 1);
      busy = 0;
      vx.delete();
      vy.delete();
      @(negedge i_Clk);
      i_Rst_L = 1'b1;
      idle(2, 1);

      // random traffic
      for (int i = 0; i < 600; i++)
         cyc(($urandom % 4) != 0, 16'($urandom), 16'($urandom), ($urandom % 4) == 0,
             ($urandom % 25) == 0, ($urandom % 3) != 0);
      idle(4, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
